histogram_fwd_param: RTL and testbench

Parametrised histogram engine with read-after-write forwarding. It streams `num_samples` values from an external sample memory and accumulates per-bin counts in an external bin memory at one sample per cycle. It optionally clears the bin memory first, saturates counts, and signals completion with a level `valid`. It is the configurable successor of the fixed 8-bit / 256-bin / 100-sample histogram kernel and sits between the two memory ports in the same kernel wrapper style.

---
 rtl/histogram_fwd_param.sv | 148 ++++++++++++++
 tb/tb_histogram_fwd_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/histogram_fwd_param.sv
// Streaming histogram engine: reads N samples, accumulates saturating per-bin counts
// in an external read-first bin memory, forwarding the previous write to hide the RAW hazard.
module histogram_fwd_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int BIN_BITS    = 8,
  parameter int COUNT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear_en,
  input  logic [ADDR_WIDTH:0]    num_samples,
  output logic [ADDR_WIDTH-1:0]  img_raddr,
  input  logic [DATA_WIDTH-1:0]  img_rdata,
  output logic [BIN_BITS-1:0]    bin_raddr,
  input  logic [COUNT_WIDTH-1:0] bin_rdata,
  output logic [BIN_BITS-1:0]    bin_waddr,
  output logic [COUNT_WIDTH-1:0] bin_wdata,
  output logic                   bin_wen,
  output logic                   busy,
  output logic                   valid,
  output logic                   sat
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]    N_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [BIN_BITS-1:0]    B_ONE   = {{(BIN_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] C_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    n_q, n_d, idx_q, idx_d;
  logic [BIN_BITS-1:0]    clr_q, clr_d;
  logic                   drain_q, drain_d;
  logic                   redo_q, redo_d;
  logic                   sat_q, sat_d;
  logic                   s1_vld_q, s1_vld_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [BIN_BITS-1:0]    s2_bin_q, s2_bin_d;
  logic                   fwd_vld_q, fwd_vld_d;
  logic [BIN_BITS-1:0]    fwd_bin_q, fwd_bin_d;
  logic [COUNT_WIDTH-1:0] fwd_val_q, fwd_val_d;

  logic [BIN_BITS-1:0]    s1_bin;
  logic [COUNT_WIDTH-1:0] old_val, new_val;

  assign s1_bin = BIN_BITS'(img_rdata >> (DATA_WIDTH - BIN_BITS));

  // fwd_vld_q is high only when the S2 write happened on the immediately preceding cycle,
  // i.e. exactly the write the read-first memory could not yet show us.
  assign old_val = (fwd_vld_q && (fwd_bin_q == s2_bin_q)) ? fwd_val_q : bin_rdata;
  assign new_val = (old_val == CNT_MAX) ? old_val : old_val + C_ONE;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    clr_d     = clr_q;
    drain_d   = drain_q;
    redo_d    = 1'b0;
    s1_vld_d  = (state_q == RUN);
    s2_vld_d  = s1_vld_q;
    s2_bin_d  = s1_vld_q ? s1_bin : s2_bin_q;
    fwd_vld_d = s2_vld_q;
    fwd_bin_d = s2_vld_q ? s2_bin_q : fwd_bin_q;
    fwd_val_d = s2_vld_q ? new_val : fwd_val_q;
    sat_d     = sat_q | (s2_vld_q & (old_val == CNT_MAX));
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d   = num_samples;
          idx_d = '0;
          clr_d = '0;
          sat_d = 1'b0;
          if (clear_en) begin
            state_d = CLEAR;
          end else if (num_samples != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            redo_d  = (state_q == DONE);
          end
        end
      end
      CLEAR: begin
        clr_d = clr_q + B_ONE;
        if (clr_q == '1) state_d = (n_q != '0) ? RUN : DONE;
      end
      RUN: begin
        idx_d = idx_q + N_ONE;
        if (idx_q == n_q - N_ONE) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      clr_q     <= '0;
      drain_q   <= 1'b0;
      redo_q    <= 1'b0;
      sat_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_bin_q  <= '0;
      fwd_vld_q <= 1'b0;
      fwd_bin_q <= '0;
      fwd_val_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      clr_q     <= clr_d;
      drain_q   <= drain_d;
      redo_q    <= redo_d;
      sat_q     <= sat_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s2_bin_q  <= s2_bin_d;
      fwd_vld_q <= fwd_vld_d;
      fwd_bin_q <= fwd_bin_d;
      fwd_val_q <= fwd_val_d;
    end
  end

  // CLEAR and an active S2 never coincide, so the write port mux needs no priority beyond this.
  assign img_raddr = (state_q == RUN) ? idx_q[ADDR_WIDTH-1:0] : '0;
  assign bin_raddr = s1_vld_q ? s1_bin : '0;
  assign bin_wen   = (state_q == CLEAR) | s2_vld_q;
  assign bin_waddr = (state_q == CLEAR) ? clr_q : (s2_vld_q ? s2_bin_q : '0);
  assign bin_wdata = ((state_q != CLEAR) && s2_vld_q) ? new_val : '0;
  assign busy      = (state_q == CLEAR) | (state_q == RUN) | (state_q == DRAIN);
  assign valid     = (state_q == DONE) & ~redo_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_histogram_fwd_param.sv
// Randomised bench for histogram_fwd_param: two instances (default and narrow/saturating)
// driven against memory models and a plain counting reference.
module tb_histogram_fwd_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // Instance A: defaults (8-bit data, 256 bins, 32-bit counts, 12-bit address)
  logic        start_a, clr_a;
  logic [12:0] num_a;
  logic [11:0] img_raddr_a;
  logic [7:0]  img_rdata_a;
  logic [7:0]  bin_raddr_a, bin_waddr_a;
  logic [31:0] bin_rdata_a, bin_wdata_a;
  logic        bin_wen_a, busy_a, valid_a, sat_a;

  // Instance B: 10-bit data, 16 bins, 4-bit counts, 6-bit address
  logic        start_b, clr_b;
  logic [6:0]  num_b;
  logic [5:0]  img_raddr_b;
  logic [9:0]  img_rdata_b;
  logic [3:0]  bin_raddr_b, bin_waddr_b;
  logic [3:0]  bin_rdata_b, bin_wdata_b;
  logic        bin_wen_b, busy_b, valid_b, sat_b;

  histogram_fwd_param dut_a (
    .clk(clk), .rst(rst), .start(start_a), .clear_en(clr_a), .num_samples(num_a),
    .img_raddr(img_raddr_a), .img_rdata(img_rdata_a),
    .bin_raddr(bin_raddr_a), .bin_rdata(bin_rdata_a),
    .bin_waddr(bin_waddr_a), .bin_wdata(bin_wdata_a), .bin_wen(bin_wen_a),
    .busy(busy_a), .valid(valid_a), .sat(sat_a)
  );

  histogram_fwd_param #(.DATA_WIDTH(10), .BIN_BITS(4), .COUNT_WIDTH(4), .ADDR_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clear_en(clr_b), .num_samples(num_b),
    .img_raddr(img_raddr_b), .img_rdata(img_rdata_b),
    .bin_raddr(bin_raddr_b), .bin_rdata(bin_rdata_b),
    .bin_waddr(bin_waddr_b), .bin_wdata(bin_wdata_b), .bin_wen(bin_wen_b),
    .busy(busy_b), .valid(valid_b), .sat(sat_b)
  );

  // Synchronous memories, one-cycle read latency, read-first on the bin memory
  logic [7:0]  img_mem_a [4096];
  logic [31:0] bin_mem_a [256];
  logic [9:0]  img_mem_b [64];
  logic [3:0]  bin_mem_b [16];

  always @(posedge clk) begin
    img_rdata_a <= img_mem_a[img_raddr_a];
    bin_rdata_a <= bin_mem_a[bin_raddr_a];
    if (bin_wen_a) bin_mem_a[bin_waddr_a] <= bin_wdata_a;
    img_rdata_b <= img_mem_b[img_raddr_b];
    bin_rdata_b <= bin_mem_b[bin_raddr_b];
    if (bin_wen_b) bin_mem_b[bin_waddr_b] <= bin_wdata_b;
  end

  longint unsigned ref_cnt [2][256];
  int samp[$];

  task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one job over the samples in samp on instance sel (0=A, 1=B).
  // A job with N=0 and no clear is only ever issued from DONE here, so valid reappears on cycle 2.
  task automatic run_job(input bit sel, input bit clr, input string tag);
    int n = samp.size();
    int nb = sel ? 16 : 256;
    int sh = sel ? 6 : 0;
    longint unsigned maxc = sel ? 64'd15 : 64'hFFFF_FFFF;
    bit exp_sat = 1'b0;
    bit seen = 1'b0;
    int exp_lat, cyc, wen_cnt, b;
    longint unsigned got;
    cyc = 0;
    wen_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (sel) img_mem_b[k] = 10'(samp[k]);
      else     img_mem_a[k] = 8'(samp[k]);
    end
    if (clr) for (int k = 0; k < nb; k++) ref_cnt[sel][k] = 0;
    for (int k = 0; k < n; k++) begin
      b = samp[k] >> sh;
      if (ref_cnt[sel][b] == maxc) exp_sat = 1'b1;
      else ref_cnt[sel][b] = ref_cnt[sel][b] + 1;
    end
    exp_lat = (clr ? nb : 0) + ((n > 0) ? n + 3 : (clr ? 1 : 2));

    @(negedge clk);
    if (sel) begin start_b = 1'b1; clr_b = clr; num_b = 7'(n); end
    else     begin start_a = 1'b1; clr_a = clr; num_a = 13'(n); end
    @(posedge clk);
    while (cyc < 6000 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_a = 1'b0;
        start_b = 1'b0;
        check_val($sformatf("%s busy", tag), sel ? busy_b : busy_a, (n == 0 && !clr) ? 0 : 1);
      end
      if (sel ? bin_wen_b : bin_wen_a) wen_cnt++;
      seen = sel ? valid_b : valid_a;
    end
    check_val($sformatf("%s latency", tag), cyc, exp_lat);
    check_val($sformatf("%s wen_cycles", tag), wen_cnt, (clr ? nb : 0) + n);
    check_val($sformatf("%s sat", tag), sel ? sat_b : sat_a, exp_sat);
    for (int k = 0; k < nb; k++) begin
      got = sel ? bin_mem_b[k] : bin_mem_a[k];
      check_val($sformatf("%s bin%0d", tag, k), got, ref_cnt[sel][k]);
    end
    $display("job %s sel=%0d clear=%0d n=%0d latency=%0d", tag, sel, clr, n, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0;
    start_a = 1'b0; clr_a = 1'b0; num_a = '0;
    start_b = 1'b0; clr_b = 1'b0; num_b = '0;
    repeat (3) @(negedge clk);
    check_val("reset busy_a", busy_a, 0);
    check_val("reset valid_a", valid_a, 0);
    check_val("reset sat_a", sat_a, 0);
    check_val("reset wen_a", bin_wen_a, 0);
    check_val("reset valid_b", valid_b, 0);
    rst = 1'b1;
    @(negedge clk);

    samp.delete();
    for (int i = 0; i < 16; i++) samp.push_back(i);
    run_job(1'b0, 1'b1, "a_ramp");

    samp.delete();
    repeat (100) samp.push_back(32'h2A);
    run_job(1'b0, 1'b1, "a_fwd42");

    samp = '{5, 5, 7, 5, 7, 7};
    run_job(1'b0, 1'b1, "a_aba");

    for (int j = 0; j < 4; j++) begin
      samp.delete();
      n = int'($urandom_range(1, 300));
      repeat (n) samp.push_back((j % 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)));
      run_job(1'b0, (j == 0) ? 1'b0 : 1'($urandom_range(0, 1)), $sformatf("a_rand%0d", j));
    end

    samp.delete();
    run_job(1'b0, 1'b0, "a_n0_redo");

    // Abort a job mid-RUN with reset, then recover with a clearing job
    for (int k = 0; k < 200; k++) img_mem_a[k] = 8'($urandom_range(0, 255));
    @(negedge clk);
    start_a = 1'b1; clr_a = 1'b0; num_a = 13'd200;
    @(negedge clk);
    start_a = 1'b0;
    repeat (50) @(negedge clk);
    check_val("midrun busy_a", busy_a, 1);
    rst = 1'b0;
    #1;
    check_val("abort busy_a", busy_a, 0);
    check_val("abort valid_a", valid_a, 0);
    check_val("abort sat_a", sat_a, 0);
    check_val("abort wen_a", bin_wen_a, 0);
    check_val("abort img_raddr_a", img_raddr_a, 0);
    check_val("abort bin_raddr_a", bin_raddr_a, 0);
    check_val("abort bin_waddr_a", bin_waddr_a, 0);
    check_val("abort bin_wdata_a", bin_wdata_a, 0);
    $display("reset asserted mid-run");
    @(negedge clk);
    rst = 1'b1;
    samp.delete();
    run_job(1'b0, 1'b1, "a_rst_clear");

    samp.delete();
    repeat (20) samp.push_back((3 << 6) | int'($urandom_range(0, 63)));
    run_job(1'b1, 1'b1, "b_sat");

    samp = '{'h3FF, 'h03F};
    run_job(1'b1, 1'b1, "b_top_bot");

    samp.delete();
    repeat (64) samp.push_back(int'($urandom_range(0, 1023)));
    run_job(1'b1, 1'b0, "b_full");

    samp.delete();
    repeat (40) samp.push_back(int'($urandom_range(0, 127)));
    run_job(1'b1, 1'b0, "b_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
